// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: NumRegs byte-strobe-writable registers with hardware load ports.
// Optional: define AXI_LITE_REG_BANK_PROT_CHECK_EN to reject unprivileged writes (aw.prot[0]==0).

package axi_lite_reg_bank_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [2:0]           prot;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

endpackage

module axi_lite_reg_bank #(
    parameter int unsigned          NumRegs      = 8,
    parameter int unsigned          AddrWidth    = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter logic [AddrWidth-1:0] BaseAddr     = '0,
    parameter logic [NumRegs-1:0]   ReadOnlyMask = '0,
    parameter logic [DataWidth-1:0] RegRstVal    = '0,
    parameter type                  req_t        = axi_lite_reg_bank_pkg::req_t,
    parameter type                  resp_t       = axi_lite_reg_bank_pkg::resp_t
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  req_t                         slv_req_i,
    output resp_t                        slv_resp_o,
    output logic [NumRegs*DataWidth-1:0] reg_q_o,
    input  logic [NumRegs-1:0]           reg_load_i,
    input  logic [NumRegs*DataWidth-1:0] reg_d_i,
    output logic [NumRegs-1:0]           reg_wr_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned AddrLsb   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef logic [DataWidth-1:0] word_t;
    typedef logic [IdxWidth-1:0]  idx_t;

    // The subtraction wraps for addr < BaseAddr, so the lower bound is tested separately.
    function automatic logic addr_in_range(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] word_off;
        word_off = (addr - BaseAddr) >> AddrLsb;
        return (addr >= BaseAddr) && (word_off < AddrWidth'(NumRegs));
    endfunction

    function automatic idx_t addr_idx(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] word_off;
        word_off = (addr - BaseAddr) >> AddrLsb;
        return idx_t'(word_off);
    endfunction

    function automatic word_t strb_mask(input logic [StrbWidth-1:0] strb);
        word_t mask;
        for (int b = 0; b < StrbWidth; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

    word_t                regs_q [NumRegs];
    logic                 aw_full_q;
    logic [AddrWidth-1:0] aw_addr_q;
    logic                 w_full_q;
    word_t                w_data_q;
    logic [StrbWidth-1:0] w_strb_q;
    logic                 b_valid_q;
    logic [1:0]           b_resp_q;
    logic                 r_valid_q;
    word_t                r_data_q;
    logic [1:0]           r_resp_q;
    logic [NumRegs-1:0]   reg_wr_q;
`ifdef AXI_LITE_REG_BANK_PROT_CHECK_EN
    logic                 aw_priv_q;
`endif

    logic               aw_hs;
    logic               w_hs;
    logic               ar_ready;
    logic               ar_hs;
    logic               commit;
    idx_t               wr_idx;
    logic               wr_ok;
    logic [NumRegs-1:0] wr_en;
    word_t              wr_mask;
    idx_t               rd_idx;
    logic               rd_in_range;

    // Protection bits feed only the optional write check; keep the rest visibly consumed.
    logic unused_prot;
    assign unused_prot = ^{slv_req_i.ar.prot, slv_req_i.aw.prot};

    assign aw_hs    = slv_req_i.aw_valid & ~aw_full_q;
    assign w_hs     = slv_req_i.w_valid & ~w_full_q;
    assign ar_ready = ~r_valid_q | slv_req_i.r_ready;
    assign ar_hs    = slv_req_i.ar_valid & ar_ready;
    assign commit   = aw_full_q & w_full_q & (~b_valid_q | slv_req_i.b_ready);

    assign wr_idx  = addr_idx(aw_addr_q);
    assign wr_mask = strb_mask(w_strb_q);
`ifdef AXI_LITE_REG_BANK_PROT_CHECK_EN
    assign wr_ok = addr_in_range(aw_addr_q) & ~ReadOnlyMask[wr_idx] & aw_priv_q;
`else
    assign wr_ok = addr_in_range(aw_addr_q) & ~ReadOnlyMask[wr_idx];
`endif

    assign rd_idx      = addr_idx(slv_req_i.ar.addr);
    assign rd_in_range = addr_in_range(slv_req_i.ar.addr);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        wr_en = '0;
        if (commit && wr_ok) begin
            wr_en[wr_idx] = 1'b1;
        end
    end

    // NOTE: non-blocking assignments only, so every read below sees the pre-edge register value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the register array is reset because its contents are visible on reg_q_o.
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= RegRstVal;
            end
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RespOkay;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RespOkay;
            reg_wr_q  <= '0;
`ifdef AXI_LITE_REG_BANK_PROT_CHECK_EN
            aw_priv_q <= 1'b0;
`endif
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= slv_req_i.aw.addr;
`ifdef AXI_LITE_REG_BANK_PROT_CHECK_EN
                aw_priv_q <= slv_req_i.aw.prot[0];
`endif
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end

            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= slv_req_i.w.data;
                w_strb_q <= slv_req_i.w.strb;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end

            if (commit) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_ok ? RespOkay : RespSlvErr;
            end else if (slv_req_i.b_ready) begin
                b_valid_q <= 1'b0;
            end

            if (ar_hs) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_in_range ? regs_q[rd_idx] : '0;
                r_resp_q  <= rd_in_range ? RespOkay : RespSlvErr;
            end else if (slv_req_i.r_ready) begin
                r_valid_q <= 1'b0;
            end

            // Hardware load wins over a bus commit to the same register.
            for (int i = 0; i < NumRegs; i++) begin
                if (reg_load_i[i]) begin
                    regs_q[i] <= reg_d_i[i*DataWidth +: DataWidth];
                end else if (wr_en[i]) begin
                    regs_q[i] <= (regs_q[i] & ~wr_mask) | (w_data_q & wr_mask);
                end
            end

            reg_wr_q <= wr_en;
        end
    end

    for (genvar i = 0; i < NumRegs; i++) begin : g_reg_out
        assign reg_q_o[i*DataWidth +: DataWidth] = regs_q[i];
    end

    assign reg_wr_o = reg_wr_q;

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = ~aw_full_q;
        slv_resp_o.w_ready  = ~w_full_q;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.b.resp   = b_resp_q;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.r_valid  = r_valid_q;
        slv_resp_o.r.data   = r_data_q;
        slv_resp_o.r.resp   = r_resp_q;
    end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank: directed scenarios plus randomized traffic
// checked against an array-based register model.

module tb_axi_lite_reg_bank;
    import axi_lite_reg_bank_pkg::*;

    localparam int          NR      = 8;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [NR-1:0] RO    = 8'b0000_0001;
    localparam logic [2:0]  PROT_OK = 3'b001;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;
    localparam int          LIMIT   = 50;

    logic               clk_i = 1'b0;
    logic               rst_i;
    req_t               req;
    resp_t              rsp;
    logic [NR*32-1:0]   reg_q;
    logic [NR-1:0]      reg_load;
    logic [NR*32-1:0]   reg_d;
    logic [NR-1:0]      reg_wr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [NR];

    axi_lite_reg_bank #(
        .NumRegs     (NR),
        .AddrWidth   (32),
        .DataWidth   (32),
        .BaseAddr    (BASE),
        .ReadOnlyMask(RO),
        .RegRstVal   (32'h0),
        .req_t       (req_t),
        .resp_t      (resp_t)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .slv_req_i (req),
        .slv_resp_o(rsp),
        .reg_q_o   (reg_q),
        .reg_load_i(reg_load),
        .reg_d_i   (reg_d),
        .reg_wr_o  (reg_wr)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout need completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [NR*32-1:0] model_vec();
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    function automatic bit exp_in_range(input logic [31:0] a);
        if (a < BASE) return 1'b0;
        return ((a - BASE) / 4) < NR;
    endfunction

    function automatic bit exp_wr_ok(input logic [31:0] a, input logic [2:0] prot);
        bit ok;
        ok = exp_in_range(a) && !RO[(a - BASE) / 4];
`ifdef AXI_LITE_REG_BANK_PROT_CHECK_EN
        ok = ok && prot[0];
`endif
        return ok;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] data,
                                        input logic [3:0] strb, input logic [2:0] prot);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (exp_wr_ok(a, prot)) model[(a - BASE) / 4] = (model[(a - BASE) / 4] & ~mask) | (data & mask);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, output logic [1:0] resp,
                            output logic [NR-1:0] wr_seen);
        int n;
        bit aw_d, w_d;
        req.aw.addr = addr;  req.aw.prot = prot;  req.aw_valid = 1'b1;
        req.w.data  = data;  req.w.strb  = strb;  req.w_valid  = 1'b1;
        req.b_ready = 1'b0;
        aw_d = 1'b0;  w_d = 1'b0;  n = 0;
        while (!(aw_d && w_d) && n < LIMIT) begin
            if (req.aw_valid && rsp.aw_ready) aw_d = 1'b1;
            if (req.w_valid && rsp.w_ready) w_d = 1'b1;
            tick();
            n++;
            if (aw_d) req.aw_valid = 1'b0;
            if (w_d) req.w_valid = 1'b0;
        end
        req.aw_valid = 1'b0;  req.w_valid = 1'b0;
        req.b_ready = 1'b1;
        wr_seen = '0;  n = 0;
        while (!rsp.b_valid && n < LIMIT) begin
            wr_seen |= reg_wr;
            tick();
            n++;
        end
        wr_seen |= reg_wr;
        resp = rsp.b.resp;
        if (n >= LIMIT) begin
            checks++;  errors++;
            $display("FAIL write_timeout addr=%h: got no b_valid need b_valid within %0d cycles", addr, LIMIT);
        end
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        bit hs;
        req.ar.addr = addr;  req.ar.prot = PROT_OK;  req.ar_valid = 1'b1;  req.r_ready = 1'b1;
        hs = 1'b0;  n = 0;
        while (!hs && n < LIMIT) begin
            #1;
            hs = rsp.ar_ready;
            tick();
            n++;
        end
        req.ar_valid = 1'b0;
        n = 0;
        while (!rsp.r_valid && n < LIMIT) begin
            tick();
            n++;
        end
        data = rsp.r.data;
        resp = rsp.r.resp;
        if (n >= LIMIT) begin
            checks++;  errors++;
            $display("FAIL read_timeout addr=%h: got no r_valid need r_valid within %0d cycles", addr, LIMIT);
        end
        tick();
        req.r_ready = 1'b0;
    endtask

    task automatic test_reset();
        req = '0;  reg_load = '0;  reg_d = '0;  rst_i = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if (reg_q !== model_vec()) begin
            errors++;  $display("FAIL reset_regs: got %h need %h", reg_q, model_vec());
        end
        checks++;
        if ({rsp.b_valid, rsp.r_valid, reg_wr} !== '0) begin
            errors++;  $display("FAIL reset_valids: got b=%b r=%b wr=%b need 0", rsp.b_valid, rsp.r_valid, reg_wr);
        end
        checks++;
        if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready} !== 3'b111) begin
            errors++;  $display("FAIL reset_ready: got %b need 111", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready});
        end
        tick();
    endtask

    task automatic test_strobe_write();
        logic [1:0] r;
        logic [NR-1:0] wr;
        logic [31:0] d;
        do_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'b0101, PROT_OK, r, wr);
        model_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'b0101, PROT_OK);
        checks++;
        if (reg_q[2*32 +: 32] !== 32'h00AD_00EF) begin
            errors++;  $display("FAIL strobe_reg2: got %h need 00ad00ef", reg_q[2*32 +: 32]);
        end
        checks++;
        if (wr !== 8'b0000_0100 || r !== OKAY) begin
            errors++;  $display("FAIL strobe_wr_resp: got wr=%b resp=%b need 00000100/00", wr, r);
        end
        do_read(BASE + 32'h8, d, r);
        checks++;
        if (d !== 32'h00AD_00EF || r !== OKAY) begin
            errors++;  $display("FAIL strobe_readback: got %h/%b need 00ad00ef/00", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        req.w.data = 32'hA5A5_A5A5;  req.w.strb = 4'hF;  req.w_valid = 1'b1;  req.b_ready = 1'b0;
        tick();
        req.w_valid = 1'b0;
        checks++;
        if (rsp.w_ready !== 1'b0 || rsp.aw_ready !== 1'b1) begin
            errors++;  $display("FAIL w_first_ready: got w=%b aw=%b need 0/1", rsp.w_ready, rsp.aw_ready);
        end
        tick();
        tick();
        req.aw.addr = BASE + 32'hC;  req.aw.prot = PROT_OK;  req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        checks++;
        if (rsp.b_valid !== 1'b0 || reg_q[3*32 +: 32] !== model[3]) begin
            errors++;  $display("FAIL w_first_early: got b_valid=%b reg3=%h need 0/%h", rsp.b_valid, reg_q[3*32 +: 32], model[3]);
        end
        tick();
        model_write(BASE + 32'hC, 32'hA5A5_A5A5, 4'hF, PROT_OK);
        checks++;
        if (rsp.b_valid !== 1'b1 || rsp.b.resp !== OKAY || reg_q[3*32 +: 32] !== model[3] || reg_wr !== 8'b0000_1000) begin
            errors++;  $display("FAIL w_first_commit: got b=%b resp=%b reg3=%h wr=%b need 1/00/%h/00001000",
                                rsp.b_valid, rsp.b.resp, reg_q[3*32 +: 32], reg_wr, model[3]);
        end
        req.aw.addr = BASE + 32'h10;  req.aw_valid = 1'b1;
        req.w.data = 32'h5A5A_5A5A;  req.w_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;  req.w_valid = 1'b0;
        checks++;
        if (rsp.aw_ready !== 1'b0 || rsp.w_ready !== 1'b0) begin
            errors++;  $display("FAIL second_buffered: got aw=%b w=%b need 0/0", rsp.aw_ready, rsp.w_ready);
        end
        tick();
        checks++;
        if (rsp.b_valid !== 1'b1 || rsp.b.resp !== OKAY || reg_q[4*32 +: 32] !== model[4]) begin
            errors++;  $display("FAIL b_held: got b=%b resp=%b reg4=%h need 1/00/%h", rsp.b_valid, rsp.b.resp, reg_q[4*32 +: 32], model[4]);
        end
        tick();
        req.b_ready = 1'b1;
        tick();
        model_write(BASE + 32'h10, 32'h5A5A_5A5A, 4'hF, PROT_OK);
        checks++;
        if (rsp.b_valid !== 1'b1 || reg_q[4*32 +: 32] !== model[4] || reg_wr !== 8'b0001_0000) begin
            errors++;  $display("FAIL second_commit: got b=%b reg4=%h wr=%b need 1/%h/00010000", rsp.b_valid, reg_q[4*32 +: 32], reg_wr, model[4]);
        end
        tick();
        req.b_ready = 1'b0;
        checks++;
        if (rsp.b_valid !== 1'b0) begin
            errors++;  $display("FAIL b_drain: got b_valid=%b need 0", rsp.b_valid);
        end
    endtask

    task automatic test_errors();
        logic [1:0] r;
        logic [NR-1:0] wr;
        logic [31:0] d;
        reg_load[0] = 1'b1;  reg_d[0 +: 32] = 32'hCAFE_0000;
        tick();
        reg_load = '0;
        model[0] = 32'hCAFE_0000;
        do_write(BASE, 32'h1234_5678, 4'hF, PROT_OK, r, wr);
        checks++;
        if (r !== SLVERR || wr !== '0 || reg_q !== model_vec()) begin
            errors++;  $display("FAIL ro_write: got resp=%b wr=%b regs=%h need 10/0/%h", r, wr, reg_q, model_vec());
        end
        do_write(BASE + 4 * NR, 32'h1234_5678, 4'hF, PROT_OK, r, wr);
        checks++;
        if (r !== SLVERR || wr !== '0 || reg_q !== model_vec()) begin
            errors++;  $display("FAIL oor_write: got resp=%b wr=%b regs=%h need 10/0/%h", r, wr, reg_q, model_vec());
        end
        do_read(BASE - 4, d, r);
        checks++;
        if (d !== 32'h0 || r !== SLVERR) begin
            errors++;  $display("FAIL below_base_read: got %h/%b need 0/10", d, r);
        end
        do_read(BASE, d, r);
        checks++;
        if (d !== model[0] || r !== OKAY) begin
            errors++;  $display("FAIL ro_read: got %h/%b need %h/00", d, r, model[0]);
        end
    endtask

    task automatic test_load_priority();
        logic [1:0] r;
        logic [NR-1:0] wr;
        logic [31:0] old;
        do_write(BASE + 4, 32'h0BAD_F00D, 4'hF, PROT_OK, r, wr);
        model_write(BASE + 4, 32'h0BAD_F00D, 4'hF, PROT_OK);
        old = model[1];
        req.aw.addr = BASE + 4;  req.aw.prot = PROT_OK;  req.aw_valid = 1'b1;
        req.w.data = 32'h2222_2222;  req.w.strb = 4'hF;  req.w_valid = 1'b1;  req.b_ready = 1'b0;
        tick();
        req.aw_valid = 1'b0;  req.w_valid = 1'b0;
        reg_load[1] = 1'b1;  reg_d[1*32 +: 32] = 32'h1111_1111;
        req.ar.addr = BASE + 4;  req.ar_valid = 1'b1;  req.r_ready = 1'b1;
        tick();
        reg_load = '0;  req.ar_valid = 1'b0;
        model[1] = 32'h1111_1111;
        checks++;
        if (reg_q[1*32 +: 32] !== 32'h1111_1111) begin
            errors++;  $display("FAIL load_wins: got %h need 11111111", reg_q[1*32 +: 32]);
        end
        checks++;
        if (rsp.b_valid !== 1'b1 || rsp.b.resp !== OKAY || reg_wr !== 8'b0000_0010) begin
            errors++;  $display("FAIL load_bus_resp: got b=%b resp=%b wr=%b need 1/00/00000010", rsp.b_valid, rsp.b.resp, reg_wr);
        end
        checks++;
        if (rsp.r_valid !== 1'b1 || rsp.r.data !== old || rsp.r.resp !== OKAY) begin
            errors++;  $display("FAIL load_read_old: got v=%b %h/%b need 1/%h/00", rsp.r_valid, rsp.r.data, rsp.r.resp, old);
        end
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;  req.r_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int beats;
        beats = 0;
        req.r_ready = 1'b1;  req.ar.addr = BASE;  req.ar_valid = 1'b1;
        for (int k = 0; k < NR; k++) begin
            tick();
            if (rsp.r_valid === 1'b1 && rsp.r.data === model[k] && rsp.r.resp === OKAY) beats++;
            else $display("FAIL b2b_beat%0d: got v=%b %h/%b need 1/%h/00", k, rsp.r_valid, rsp.r.data, rsp.r.resp, model[k]);
            if (k < NR - 1) req.ar.addr = BASE + 4 * (k + 1);
            else req.ar_valid = 1'b0;
        end
        checks++;
        if (beats !== NR) begin
            errors++;  $display("FAIL b2b_count: got %0d need %0d", beats, NR);
        end
        tick();
        req.r_ready = 1'b0;
        checks++;
        if (rsp.r_valid !== 1'b0) begin
            errors++;  $display("FAIL b2b_drain: got r_valid=%b need 0", rsp.r_valid);
        end
    endtask

    task automatic test_prot();
        logic [1:0] r;
        logic [NR-1:0] wr;
        do_write(BASE + 32'h14, 32'h7777_0000, 4'hF, 3'b000, r, wr);
        model_write(BASE + 32'h14, 32'h7777_0000, 4'hF, 3'b000);
        checks++;
`ifdef AXI_LITE_REG_BANK_PROT_CHECK_EN
        if (r !== SLVERR || wr !== '0 || reg_q !== model_vec()) begin
            errors++;  $display("FAIL prot_unpriv: got resp=%b wr=%b reg5=%h need 10/0/%h", r, wr, reg_q[5*32 +: 32], model[5]);
        end
`else
        if (r !== OKAY || wr !== 8'b0010_0000 || reg_q !== model_vec()) begin
            errors++;  $display("FAIL prot_ignored: got resp=%b wr=%b reg5=%h need 00/00100000/%h", r, wr, reg_q[5*32 +: 32], model[5]);
        end
`endif
        do_write(BASE + 32'h14, 32'h0000_9999, 4'hF, 3'b001, r, wr);
        model_write(BASE + 32'h14, 32'h0000_9999, 4'hF, 3'b001);
        checks++;
        if (r !== OKAY || reg_q !== model_vec()) begin
            errors++;  $display("FAIL prot_priv: got resp=%b reg5=%h need 00/%h", r, reg_q[5*32 +: 32], model[5]);
        end
    endtask

    task automatic test_random();
        logic [31:0]   addr, data, d;
        logic [3:0]    strb;
        logic [2:0]    prot;
        logic [1:0]    r, er;
        logic [NR-1:0] wr, ewr;
        int            sel;
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 11);
            if (sel < 8) addr = BASE + 4 * sel + $urandom_range(0, 3);
            else if (sel < 10) addr = BASE + 4 * sel;
            else addr = BASE - 4 * $urandom_range(1, 3);
            data = $urandom;
            strb = 4'($urandom);
            prot = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                er  = exp_wr_ok(addr, prot) ? OKAY : SLVERR;
                ewr = exp_wr_ok(addr, prot) ? NR'(1) << ((addr - BASE) / 4) : '0;
                model_write(addr, data, strb, prot);
                do_write(addr, data, strb, prot, r, wr);
                checks++;
                if (r !== er || wr !== ewr || reg_q !== model_vec()) begin
                    errors++;  $display("FAIL rand_write%0d addr=%h: got resp=%b wr=%b need %b/%b (regs %s)",
                                        it, addr, r, wr, er, ewr, (reg_q === model_vec()) ? "ok" : "differ");
                end
            end else begin
                do_read(addr, d, r);
                checks++;
                if (exp_in_range(addr)) begin
                    if (d !== model[(addr - BASE) / 4] || r !== OKAY) begin
                        errors++;  $display("FAIL rand_read%0d addr=%h: got %h/%b need %h/00", it, addr, d, r, model[(addr - BASE) / 4]);
                    end
                end else if (d !== 32'h0 || r !== SLVERR) begin
                    errors++;  $display("FAIL rand_read%0d addr=%h: got %h/%b need 0/10", it, addr, d, r);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        req.aw.addr = BASE + 32'h18;  req.aw.prot = PROT_OK;  req.aw_valid = 1'b1;
        req.w.data = 32'hFFFF_FFFF;  req.w.strb = 4'hF;  req.w_valid = 1'b1;  req.b_ready = 1'b0;
        tick();
        req.aw_valid = 1'b0;  req.w_valid = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        #1;
        checks++;
        if (rsp.b_valid !== 1'b0 || rsp.aw_ready !== 1'b1 || rsp.w_ready !== 1'b1 || reg_q !== model_vec()) begin
            errors++;  $display("FAIL mid_reset: got b=%b aw=%b w=%b regs=%h need 0/1/1/0", rsp.b_valid, rsp.aw_ready, rsp.w_ready, reg_q);
        end
        tick();
        tick();
        tick();
        checks++;
        if (rsp.b_valid !== 1'b0 || reg_wr !== '0) begin
            errors++;  $display("FAIL mid_reset_no_resp: got b=%b wr=%b need 0/0", rsp.b_valid, reg_wr);
        end
    endtask

    initial begin
        test_reset();
        test_strobe_write();
        test_w_before_aw();
        test_errors();
        test_load_priority();
        test_back_to_back();
        test_prot();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
